// File: rtl/instr_decode_pipe.sv
// Elastic instruction-decode stage: splits the packed word into fields, flags illegal
// encodings, and buffers up to two entries (main + skid). ID_STATS_EN adds handshake counters.
module instr_decode_pipe #(
  parameter int               OPC_W      = 8,
  parameter int               MODE_W     = 2,
  parameter int               OPND_W     = 16,
  parameter logic [OPC_W-1:0] MAX_OPCODE = 'h3F,
  parameter int               NUM_REGS   = 16,
  localparam int              INSTR_W    = OPC_W + 2*(MODE_W+OPND_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   opcode,
  output logic [MODE_W-1:0]  mode1,
  output logic [OPND_W-1:0]  op1,
  output logic [MODE_W-1:0]  mode2,
  output logic [OPND_W-1:0]  op2,
  output logic               illegal,
`ifdef ID_STATS_EN
  input  logic               stat_clr,
  output logic [31:0]        stat_decoded,
  output logic [31:0]        stat_illegal,
`endif
  output logic [1:0]         dbg_state
);

  localparam int M1_LSB = OPC_W;
  localparam int O1_LSB = OPC_W + MODE_W;
  localparam int M2_LSB = OPC_W + MODE_W + OPND_W;
  localparam int O2_LSB = OPC_W + 2*MODE_W + OPND_W;
  localparam logic [OPND_W:0] NREG = (OPND_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_in_ready;
  logic [INSTR_W-1:0] r_main_word;
  logic [INSTR_W-1:0] r_skid_word;
  logic               r_main_ill;
  logic               r_skid_ill;

  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_load_main_in;
  logic               w_load_main_skid;
  logic               w_load_skid;
  logic               w_in_illegal;

  logic [OPC_W-1:0]   w_in_opc;
  logic [MODE_W-1:0]  w_in_m1;
  logic [OPND_W-1:0]  w_in_o1;
  logic [MODE_W-1:0]  w_in_m2;
  logic [OPND_W-1:0]  w_in_o2;

  assign w_in_opc = instruction[OPC_W-1:0];
  assign w_in_m1  = instruction[M1_LSB +: MODE_W];
  assign w_in_o1  = instruction[O1_LSB +: OPND_W];
  assign w_in_m2  = instruction[M2_LSB +: MODE_W];
  assign w_in_o2  = instruction[O2_LSB +: OPND_W];

  // Only register-mode operands are range-checked against the register file.
  assign w_in_illegal = (w_in_opc > MAX_OPCODE)
                      | ((w_in_m1 == '0) & ({1'b0, w_in_o1} >= NREG))
                      | ((w_in_m2 == '0) & ({1'b0, w_in_o2} >= NREG));

  assign in_ready   = r_in_ready;
  assign out_valid  = (r_state != ST_EMPTY);
  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign dbg_state  = r_state;

  // Valid/ready: a word moves when valid and ready are both high at a posedge; while
  // out_valid is high and out_ready low, the outputs hold. in_ready is a registered !skid_full.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt    = ST_ONE;
            w_load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main_in = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end else if (w_in_fire) begin
            w_state_nxt = ST_TWO;
            w_load_skid = 1'b1;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            w_state_nxt      = ST_ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_main_word <= '0;
      r_main_ill  <= 1'b0;
      r_skid_word <= '0;
      r_skid_ill  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_TWO);
      if (w_load_main_in) begin
        r_main_word <= instruction;
        r_main_ill  <= w_in_illegal;
      end else if (w_load_main_skid) begin
        r_main_word <= r_skid_word;
        r_main_ill  <= r_skid_ill;
      end
      if (w_load_skid) begin
        r_skid_word <= instruction;
        r_skid_ill  <= w_in_illegal;
      end
    end
  end

  assign opcode  = r_main_word[OPC_W-1:0];
  assign mode1   = r_main_word[M1_LSB +: MODE_W];
  assign op1     = r_main_word[O1_LSB +: OPND_W];
  assign mode2   = r_main_word[M2_LSB +: MODE_W];
  assign op2     = r_main_word[O2_LSB +: OPND_W];
  assign illegal = r_main_ill;

`ifdef ID_STATS_EN
  logic [31:0] r_stat_decoded;
  logic [31:0] r_stat_illegal;

  // Counters survive flush; stat_clr wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_decoded <= '0;
      r_stat_illegal <= '0;
    end else if (stat_clr) begin
      r_stat_decoded <= '0;
      r_stat_illegal <= '0;
    end else if (w_out_fire) begin
      r_stat_decoded <= r_stat_decoded + 32'd1;
      if (r_main_ill) r_stat_illegal <= r_stat_illegal + 32'd1;
    end
  end

  assign stat_decoded = r_stat_decoded;
  assign stat_illegal = r_stat_illegal;
`endif

endmodule

// File: doc/instr_decode_pipe.md
Name: instr_decode_pipe

Overview:
- Parametrised, elastic instruction-decode stage for the RISC-Net pipeline, sitting between fetch and execute.
- Splits a packed instruction word into opcode, two addressing modes and two operands.
- Flags illegal encodings.
- Decouples fetch and execute with a valid/ready handshake and a 2-entry skid buffer, so full throughput holds under backpressure.
- Supports a synchronous pipeline flush.

Parameters:
- OPC_W, 8, opcode field width.
- MODE_W, 2, width of each addressing-mode field.
- OPND_W, 16, width of each operand field.
- MAX_OPCODE, 8'h3F, highest legal opcode; larger values are illegal.
- NUM_REGS, 16, register-file size; a register-mode operand must be < NUM_REGS.
- Derived localparam INSTR_W = OPC_W + 2*(MODE_W+OPND_W), 44 with defaults.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  discard all buffered instructions
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept
- instruction  in  INSTR_W  packed word
- out_valid  out  1  decoded fields valid
- out_ready  in  1  execute accepts
- opcode  out  OPC_W  decoded opcode
- mode1  out  MODE_W  operand-1 mode
- op1  out  OPND_W  operand 1
- mode2  out  MODE_W  operand-2 mode
- op2  out  OPND_W  operand 2
- illegal  out  1  decoded instruction is illegal

Behaviour:
- Field layout, LSB first:
  - opcode = [OPC_W-1:0]
  - mode1 next, then op1, then mode2, then op2 in the MSBs
  - Defaults: [7:0] opcode, [9:8] mode1, [25:10] op1, [27:26] mode2, [43:28] op2.
- Mode encoding: 0 register, 1 immediate, 2 direct memory, 3 indirect. Only 0 is range-checked.
- illegal = (opcode > MAX_OPCODE) | (mode1==0 & op1>=NUM_REGS) | (mode2==0 & op2>=NUM_REGS).
  - Computed at capture and stored with the entry.
  - Fields still pass through unchanged.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - in_ready is a registered signal, equal to !skid_full. Never combinationally dependent on out_ready.
  - Outputs hold stable while out_valid & !out_ready.
- Buffer states:
  - EMPTY: main and skid empty.
  - ONE: main full.
  - TWO: main and skid full.
- Transitions:
  - EMPTY + in -> ONE. Main is loaded; out_valid rises the cycle after acceptance (1-cycle latency).
  - ONE + in + out -> ONE. Main is reloaded.
  - ONE + out only -> EMPTY.
  - ONE + in only -> TWO. The new word goes to skid; in_ready drops next cycle.
  - TWO + out -> ONE. Skid moves to main; in_ready rises next cycle. No input is accepted in TWO.
- Ordering is strictly FIFO. No instruction is dropped or duplicated.
- flush, synchronous, highest priority after reset:
  - Next state EMPTY, out_valid=0, in_ready=1.
  - Any input offered in the flush cycle is discarded.
  - An output handshake in the same cycle still counts as delivered.
- Reset (rst_n=0 at posedge), also mid-stream:
  - State EMPTY.
  - out_valid=0, in_ready=1.
  - opcode, mode1, op1, mode2, op2 and illegal are all 0.
- Data registers update only on load. They need no clearing on flush.

Optional Feature:
- Macro: ID_STATS_EN.
- With the macro defined:
  - Adds output stat_decoded (32 bits), incremented on every output handshake.
  - Adds output stat_illegal (32 bits), incremented on output handshakes with illegal=1.
  - Both wrap modulo 2^32.
  - Both clear on reset; neither clears on flush.
  - Adds input stat_clr (1 bit): synchronous clear. If an increment coincides with stat_clr, the counter reads 0 next cycle.
- Without the macro: the ports and the logic are absent, and decode behaviour is identical.

Test Plan:
- Basic decode:
  - Stimulus: reset, then present 44'h0003048D105 with out_ready=1.
  - Response: next cycle out_valid=1, opcode=8'h05, mode1=1, op1=16'h1234, mode2=0, op2=16'h0003, illegal=0.
- Illegal opcode and register range:
  - Stimulus: present opcode 8'h40 with legal operands, then opcode 8'h01, mode1=0, op1=16'h0010.
  - Response: illegal=1 for both; all fields passed through.
- Backpressure:
  - Stimulus: stream I0..I5 with in_valid=1, hold out_ready=0 for 4 cycles, then release.
  - Response: in_ready drops after 2 accepts and I0 stays on the outputs. After release, I0..I5 exit in order, one per cycle, with no loss.
- Full throughput:
  - Stimulus: in_valid=1 and out_ready=1 continuously for 20 words.
  - Response: 20 outputs on consecutive cycles, in_ready constant 1.
- Flush in TWO:
  - Stimulus: fill both entries, assert flush for one cycle while offering I2.
  - Response: next cycle out_valid=0, in_ready=1; I2 never appears; the next accepted word emerges correctly.
- Reset mid-stream, plus stats (with ID_STATS_EN):
  - Stimulus: deliver 3 legal and 2 illegal words, then pulse rst_n=0 while the buffer is full.
  - Response: stat_decoded=5 and stat_illegal=2 before the reset pulse. After reset: all outputs 0, in_ready=1, both counters 0.
